// File: rtl/move_avg_multi_if.sv
// Sample stream bundle for move_avg_multi: input side and output side valid/ready pairs.
// The block uses the slave modport; the sample producer/consumer uses master.
interface move_avg_multi_if #(
   parameter int WIDTH = 24,
   parameter int CW    = 1
);
   logic [WIDTH-1:0] in_data;
   logic [CW-1:0]    in_channel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_channel;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  in_data, in_channel, in_valid, out_ready,
      output in_ready, out_data, out_channel, out_valid
   );

   modport master (
      output in_data, in_channel, in_valid, out_ready,
      input  in_ready, out_data, out_channel, out_valid
   );
endinterface

// File: rtl/move_avg_multi.sv
// Multi-channel moving average with per-channel circular history and running sum, window 2^k.
// Latency 1 cycle; in_ready drops combinationally while the output is stalled or history clears.
module move_avg_multi #(
   parameter int WIDTH    = 24,
   parameter int LOG2_MAX = 3,
   parameter int CHANNELS = 2,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int LW = $clog2(LOG2_MAX + 1)
) (
   input  logic              clk,
   input  logic              reset,
   move_avg_multi_if.slave   io,
   input  logic              on,
   input  logic [LW-1:0]     len_sel,
   output logic              busy
);
   localparam int MAX = 1 << LOG2_MAX;
   localparam int AW  = WIDTH + LOG2_MAX;

   typedef enum logic {RUN, CLEAR} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic signed [WIDTH-1:0]   r_hist [CHANNELS][MAX];
   logic [LOG2_MAX-1:0]       r_wp   [CHANNELS];
   logic signed [AW-1:0]      r_acc  [CHANNELS];
   logic [LW-1:0]             r_k;
   logic [LOG2_MAX-1:0]       r_idx;
   logic signed [WIDTH-1:0]   r_out_dat;
   logic [CW-1:0]             r_out_ch;
   logic                      r_out_vld;

   logic [LW-1:0]             w_len;
   logic                      w_len_chg;
   logic                      w_ch_ok;
   logic [CW-1:0]             w_ch;
   logic                      w_take;
   logic [LOG2_MAX-1:0]       w_step;
   logic [LOG2_MAX-1:0]       w_rd;
   logic signed [WIDTH-1:0]   w_x;
   logic signed [WIDTH-1:0]   w_old;
   logic signed [AW-1:0]      w_acc_nxt;
   logic signed [AW-1:0]      w_rnd;
   logic signed [AW-1:0]      w_sum;
   logic signed [WIDTH-1:0]   w_avg;

   assign w_len     = (len_sel > LW'(LOG2_MAX)) ? LW'(LOG2_MAX) : len_sel;
   assign w_len_chg = (w_len != r_k);
   assign w_ch_ok   = ({1'b0, io.in_channel} < (CW+1)'(CHANNELS));
   assign w_ch      = w_ch_ok ? io.in_channel : '0;
   assign w_take    = io.in_valid && io.in_ready && w_ch_ok;

   // A full-length window wraps the step to zero, so the slot being overwritten is the one retired.
   assign w_step    = LOG2_MAX'(1) << r_k;
   assign w_rd      = r_wp[w_ch] - w_step;
   assign w_x       = $signed(io.in_data);
   assign w_old     = r_hist[w_ch][w_rd];
   assign w_acc_nxt = r_acc[w_ch] + AW'(w_x) - AW'(w_old);
   assign w_rnd     = (r_k == '0) ? '0 : (AW'(1) << (r_k - LW'(1)));
   assign w_sum     = w_acc_nxt + w_rnd;
   assign w_avg     = WIDTH'(w_sum >>> r_k);

   assign io.out_data    = r_out_dat;
   assign io.out_channel = r_out_ch;
   assign io.out_valid   = r_out_vld;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      io.in_ready = 1'b0;
      case (r_state)
         RUN: begin
            io.in_ready = reset && (!r_out_vld || io.out_ready);
            if (w_len_chg) w_state_nxt = CLEAR;
         end
         CLEAR: begin
            busy = 1'b1;
            if (&r_idx) w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int s = 0; s < MAX; s++) r_hist[c][s] <= '0;
            r_wp[c]  <= '0;
            r_acc[c] <= '0;
         end
         r_k       <= '0;
         r_idx     <= '0;
         r_out_dat <= '0;
         r_out_ch  <= '0;
         r_out_vld <= 1'b0;
      end else begin
         if (r_state == RUN) begin
            if (w_len_chg) begin
               r_k   <= w_len;
               r_idx <= '0;
            end
            if (w_take) begin
               r_hist[w_ch][r_wp[w_ch]] <= w_x;
               r_wp[w_ch]               <= r_wp[w_ch] + LOG2_MAX'(1);
               r_acc[w_ch]              <= w_acc_nxt;
            end
         end else begin
            for (int c = 0; c < CHANNELS; c++) r_hist[c][r_idx] <= '0;
            r_idx <= r_idx + LOG2_MAX'(1);
            if (&r_idx) begin
               for (int c = 0; c < CHANNELS; c++) begin
                  r_acc[c] <= '0;
                  r_wp[c]  <= '0;
               end
            end
         end

         // A new sample replaces the retiring one in the same cycle, so there is no bubble.
         if (w_take) begin
            r_out_vld <= 1'b1;
            r_out_dat <= on ? w_avg : w_x;
            r_out_ch  <= w_ch;
         end else if (io.out_ready) begin
            r_out_vld <= 1'b0;
         end
      end
   end
endmodule

// File: doc/move_avg_multi.md
# move_avg_multi

Parametrised, multi-channel moving-average filter for the mixer synthesis chain, placed between a sample source and the next DSP stage on the 24-bit streaming path. It keeps a per-channel circular history and a running sum, supports a runtime-selectable power-of-two window, and has full valid/ready backpressure on both sides. Bypass mode passes samples through unchanged while still updating history, so enabling the filter yields a correct average immediately.

## Interface
- WIDTH, 24: sample width; two's-complement signed.
- LOG2_MAX, 3: log2 of the maximum window; MAX = 2^LOG2_MAX, legal range 1..6.
- CHANNELS, 2: number of interleaved channels; legal range 1..8.
- CW, derived: channel index width, max(1, clog2(CHANNELS)).
- LW, derived: clog2(LOG2_MAX+1).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  input sample.
- in_channel  in  CW  channel of in_data.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts a sample this cycle.
- out_data  out  WIDTH  filtered (or bypassed) sample.
- out_channel  out  CW  channel of out_data.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts out_data.
- on  in  1  1 = average, 0 = bypass.
- len_sel  in  LW  window length L = 2^len_sel; values > LOG2_MAX clamp to LOG2_MAX.
- busy  out  1  high while history is being cleared.

## Operation
- Storage per channel: MAX x WIDTH history array, write pointer wp (LOG2_MAX bits), accumulator acc (WIDTH+LOG2_MAX bits, signed).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = (state == RUN) && (!out_valid || out_ready).
- On accepted sample x for channel c, with k = active length exponent:
  - old = hist[c][(wp[c] - 2^k) mod MAX], read before the write (k = LOG2_MAX reads the slot being overwritten).
  - acc[c] <= acc[c] + x - old; hist[c][wp[c]] <= x; wp[c] <= wp[c] + 1 (wraps mod MAX).
  - Average: avg = (acc_new + (k>0 ? 2^(k-1) : 0)) >>> k, truncated to WIDTH; round-half-up, no saturation needed.
  - out_data <= on ? avg : x; out_channel <= c; out_valid <= 1.
- in_channel >= CHANNELS: sample accepted and discarded; no state change, no output.
- History updates identically in bypass and averaging modes.
- State machine, two states:
  - RUN: normal operation. If clamped len_sel != active k: latch new k, zero clear index, go CLEAR.
  - CLEAR: busy = 1, in_ready = 0; each cycle zeroes slot [idx] of every channel's history; after MAX cycles zero all acc and wp, go RUN.
  - Pending output (out_valid = 1) survives CLEAR and is drained normally by out_ready.
  - A len_sel change during CLEAR is ignored until RUN is re-entered, then re-triggers CLEAR.
- Reset (reset = 0, asynchronous): history, acc, wp zeroed; k = 0; state RUN; out_data = 0, out_channel = 0, out_valid = 0, busy = 0, in_ready = 0 while asserted. If len_sel != 0 on release, CLEAR runs first.

## Timing
- Latency: accepted sample appears on out_data in the following cycle (one register stage).
- Throughput: one sample per cycle with out_ready held high.
- Backpressure: out_valid && !out_ready holds out_data/out_channel/out_valid stable and drops in_ready combinationally in the same cycle.
- Simultaneous output and input transfer in one cycle: old output retires, new output loaded; no bubble.
- CLEAR lasts exactly MAX cycles; in_ready goes low the cycle after the len_sel change is sampled and returns high the cycle after busy falls.
- on is sampled at input-transfer time; toggling on never flushes history.
- Reset asserted mid-stream: all outputs reach reset values without waiting for clk; an in-flight output is lost.

## Test plan
- CHANNELS=2, LOG2_MAX=3, len_sel=2 (L=4), on=1; ch0 samples 4, 8, 12, 16 -> out_data 1, 3, 6, 10, out_channel 0, one cycle after each accept.
- len_sel=1, ch0 samples -3, -4 -> out_data -1, -3 (round half toward +infinity).
- len_sel=1, interleaved ch0 100, ch1 -100, ch0 100, ch1 -100 -> outputs 50/ch0, -50/ch1, 100/ch0, -100/ch1; channels independent.
- Stream with out_ready low for 3 cycles -> out_data held, in_ready low for those 3 cycles, no sample lost or duplicated, sequence resumes unchanged.
- After data at L=4, set len_sel=3 with one output pending -> pending output still delivered; busy high exactly 8 cycles; then ch0 sample 40 -> out_data 5.
- on=0, L=4, ch0 four samples of 20 -> outputs equal inputs; set on=1, sample 20 -> 20. Assert reset mid-stream -> out_valid 0 and out_data 0 immediately, and the first output after release averages from zero history.
